// File: rtl/rv_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_pkg : shared types and constants for the port-B store path | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv_mem_pkg;

   localparam int NUM_COL   = 4;
   localparam int COL_WIDTH = 8;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} mem_size_t;

   typedef enum logic [0:0] {IDLE, WR2} store_state_t;

   // Unshifted byte-enable pattern for an access of the given size.
   function automatic logic [NUM_COL-1:0] size_mask(input mem_size_t sz);
      case (sz)
         SZ_B:    size_mask = 4'b0001;
         SZ_H:    size_mask = 4'b0011;
         SZ_W:    size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv_store_lane.sv
// ---------------------------------------------------------------------------
// rv_store_lane : byte-offset shift of store data and enables over two words
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv_store_lane
   import rv_mem_pkg::*;
(
   input  logic [1:0]                       size_i,
   input  logic [1:0]                       off_i,
   input  logic [NUM_COL*COL_WIDTH-1:0]     data_i,
   output logic [2*NUM_COL-1:0]             mask8_o,
   output logic [2*NUM_COL*COL_WIDTH-1:0]   data64_o
);

   logic [NUM_COL-1:0] w_base;

   assign w_base   = size_mask(mem_size_t'(size_i));
   assign mask8_o  = {{NUM_COL{1'b0}}, w_base} << off_i;
   assign data64_o = {{(NUM_COL*COL_WIDTH){1'b0}}, data_i} << {off_i, 3'b000};

endmodule

`default_nettype wire

// File: rtl/rv_store_unit.sv
// ---------------------------------------------------------------------------
// rv_store_unit : core store requests -> registered dpram port-B writes.
// Optional macro STORE_SPLIT_EN splits word-straddling stores in two.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv_store_unit #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_COL    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  enaB,
   output logic [NUM_COL-1:0]    weB,
   output logic [ADDR_WIDTH-1:0] addrB,
   output logic [DATA_WIDTH-1:0] dinB,
   output logic                  done,
   output logic                  err
);

   import rv_mem_pkg::*;

   logic [2*NUM_COL-1:0]    w_mask8;
   logic [2*DATA_WIDTH-1:0] w_data64;
   logic [ADDR_WIDTH-1:0]   w_word;
   logic                    w_accept;
   logic                    w_illegal;
   logic                    w_straddle;

   logic                    ena_q,  ena_d;
   logic [NUM_COL-1:0]      we_q,   we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q,  din_d;
   logic                    done_q, done_d;
   logic                    err_q,  err_d;

   rv_store_lane u_lane (
      .size_i   (req_size),
      .off_i    (req_addr[1:0]),
      .data_i   (req_data),
      .mask8_o  (w_mask8),
      .data64_o (w_data64)
   );

   assign w_word     = req_addr[ADDR_WIDTH+1:2];
   assign w_accept   = req_valid && req_ready;
   assign w_illegal  = (req_size == SZ_X);
   assign w_straddle = |w_mask8[2*NUM_COL-1:NUM_COL];

`ifdef STORE_SPLIT_EN
   store_state_t            state_q, state_d;
   logic [NUM_COL-1:0]      hi_we_q,   hi_we_d;
   logic [ADDR_WIDTH-1:0]   hi_addr_q, hi_addr_d;
   logic [DATA_WIDTH-1:0]   hi_din_q,  hi_din_d;

   assign req_ready = (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hi_we_q   <= '0;
         hi_addr_q <= '0;
         hi_din_q  <= '0;
      end else begin
         state_q   <= state_d;
         hi_we_q   <= hi_we_d;
         hi_addr_q <= hi_addr_d;
         hi_din_q  <= hi_din_d;
      end
   end
`else
   logic w_unused_hi;

   assign req_ready   = 1'b1;
   assign w_unused_hi = ^w_data64[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

   always_comb begin
      ena_d  = 1'b0;
      we_d   = '0;
      addr_d = addr_q;
      din_d  = din_q;
      done_d = 1'b0;
      err_d  = 1'b0;
`ifdef STORE_SPLIT_EN
      state_d   = state_q;
      hi_we_d   = hi_we_q;
      hi_addr_d = hi_addr_q;
      hi_din_d  = hi_din_q;
      if (state_q == WR2) begin
         ena_d   = 1'b1;
         we_d    = hi_we_q;
         addr_d  = hi_addr_q;
         din_d   = hi_din_q;
         done_d  = 1'b1;
         state_d = IDLE;
      end else
`endif
      if (w_accept) begin
         if (w_illegal) begin
            err_d = 1'b1;
         end else if (w_straddle) begin
`ifdef STORE_SPLIT_EN
            ena_d     = 1'b1;
            we_d      = w_mask8[NUM_COL-1:0];
            addr_d    = w_word;
            din_d     = w_data64[DATA_WIDTH-1:0];
            state_d   = WR2;
            // Word address wraps naturally at the top of the RAM.
            hi_we_d   = w_mask8[2*NUM_COL-1:NUM_COL];
            hi_addr_d = w_word + ADDR_WIDTH'(1);
            hi_din_d  = w_data64[2*DATA_WIDTH-1:DATA_WIDTH];
`else
            err_d = 1'b1;
`endif
         end else begin
            ena_d  = 1'b1;
            we_d   = w_mask8[NUM_COL-1:0];
            addr_d = w_word;
            din_d  = w_data64[DATA_WIDTH-1:0];
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ena_q  <= 1'b0;
         we_q   <= '0;
         addr_q <= '0;
         din_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ena_q  <= ena_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         din_q  <= din_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign enaB  = ena_q;
   assign weB   = we_q;
   assign addrB = addr_q;
   assign dinB  = din_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

`default_nettype wire
